// File: rtl/axi_stream_frame_writer.sv
// axi_stream_frame_writer: writes framed stream packets into a word buffer from address 0.
// Define AXIS_FRAME_WRITER_CHECK_EN to enable start/framing checks and orphan-beat dropping.
module axi_stream_frame_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_start,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  frame_done,
    output logic [ADDR_WIDTH:0]   frame_len,
    output logic                  frame_err,
    output logic [7:0]            drop_cnt,
    input  logic                  frame_ack
);
    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
    localparam logic [ADDR_WIDTH:0] LEN_MAX = '1;
    state_t              state;
    logic [ADDR_WIDTH:0] count;
    logic [7:0]          drops;
    logic                fire;
    logic                begin_frame;
    logic                start_err;
    assign s_ready   = state != DONE;
    assign fire      = s_valid & s_ready;
    assign frame_len = count;
    assign drop_cnt  = drops;
`ifdef AXIS_FRAME_WRITER_CHECK_EN
    assign begin_frame = s_start;
    assign start_err   = s_start;
`else
    logic unused_start;
    assign unused_start = s_start;
    assign begin_frame  = 1'b1;
    assign start_err    = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            frame_err  <= 1'b0;
            frame_done <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            drops      <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: if (fire) begin
                    if (begin_frame) begin
                        mem_we     <= 1'b1;
                        mem_addr   <= '0;
                        mem_wdata  <= s_data;
                        count      <= 1;
                        frame_err  <= 1'b0;
                        frame_done <= s_last;
                        state      <= s_last ? DONE : RECV;
                    end else if (drops != 8'hFF) begin
                        drops <= drops + 8'd1;
                    end
                end
                RECV: if (fire) begin
                    // count[ADDR_WIDTH] set means the buffer is full: accept but do not write
                    mem_we    <= ~count[ADDR_WIDTH];
                    mem_addr  <= count[ADDR_WIDTH-1:0];
                    mem_wdata <= s_data;
                    if (count != LEN_MAX) count <= count + 1'b1;
                    if (start_err || count[ADDR_WIDTH]) frame_err <= 1'b1;
                    if (s_last) begin
                        frame_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: if (frame_ack) begin
                    count      <= '0;
                    frame_err  <= 1'b0;
                    frame_done <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_stream_frame_writer.sv
// tb_axi_stream_frame_writer: directed and random frames checked against a per-frame reference model.
module tb_axi_stream_frame_writer;
    localparam int DW = 32, AW = 3, DEPTH = 8, LMAX = 15;
`ifdef AXIS_FRAME_WRITER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst, s_valid, s_start, s_last, s_ready, mem_we, frame_done, frame_err, frame_ack;
    logic [DW-1:0] s_data, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [AW:0]   frame_len;
    logic [7:0]    drop_cnt;
    int checks = 0, failures = 0, model_drops = 0;
    logic [DW-1:0] bd[$];
    bit bs[$], bl[$];
    logic [AW+DW-1:0] wq[$];

    axi_stream_frame_writer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_start(s_start),
        .s_last(s_last), .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .frame_done(frame_done), .frame_len(frame_len),
        .frame_err(frame_err), .drop_cnt(drop_cnt), .frame_ack(frame_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [DW-1:0] d, input bit s, input bit l);
        bd.push_back(d);
        bs.push_back(s);
        bl.push_back(l);
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", s_ready, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_len", frame_len, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_drop", drop_cnt, 0);
    endtask

    // Model: leading non-start beats are orphans (check build only); the rest form one frame.
    task automatic run(input bit rnd);
        logic [AW+DW-1:0] ew[$];
        int n = 0;
        bit in_frame = 0, err = 0, wrote_last;
        foreach (bd[i]) begin
            if (!in_frame && CHK && !bs[i]) begin
                if (model_drops < 255) model_drops++;
            end else begin
                if (in_frame && CHK && bs[i]) err = 1;
                in_frame = 1;
                if (n < DEPTH) ew.push_back({n[AW-1:0], bd[i]});
                else err = 1;
                n++;
            end
        end
        wrote_last = n <= DEPTH;
        wq.delete();
        foreach (bd[i]) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                s_valid = 0;
                s_data = $urandom;
                s_start = 1'($urandom_range(0, 1));
                s_last = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            chk("ready_in_frame", s_ready, 1);
            s_valid = 1;
            s_data = bd[i];
            s_start = bs[i];
            s_last = bl[i];
            frame_ack = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        s_valid = 0; s_start = 0; s_last = 0; frame_ack = 0;
        chk("done_rise", frame_done, 1);
        chk("ready_low", s_ready, 0);
        chk("last_we", mem_we, wrote_last);
        if (wrote_last) chk("last_addr", mem_addr, n - 1);
        chk("len", frame_len, n > LMAX ? LMAX : n);
        chk("err", frame_err, err);
        chk("drop_cnt", drop_cnt, CHK ? model_drops : 0);
        repeat (2) @(negedge clk);
        chk("hold_ready", s_ready, 0);
        chk("hold_done", frame_done, 1);
        chk("hold_len", frame_len, n > LMAX ? LMAX : n);
        chk("hold_err", frame_err, err);
        frame_ack = 1;
        @(negedge clk);
        frame_ack = 0;
        chk("ack_ready", s_ready, 1);
        chk("ack_done", frame_done, 0);
        chk("ack_len", frame_len, 0);
        chk("ack_err", frame_err, 0);
        chk("n_writes", wq.size(), ew.size());
        foreach (ew[i]) if (i < wq.size()) chk("write", wq[i], ew[i]);
        bd.delete(); bs.delete(); bl.delete();
    endtask

    initial begin
        rst = 1; s_valid = 0; s_start = 0; s_last = 0; s_data = '0; frame_ack = 0;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        rst = 0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) add(32'hA0 + i, i == 0, i == 3);
        run(0);
        add(32'h55, 1, 1);
        run(0);
        for (int i = 0; i < 3; i++) add(32'h70 + i, 0, 0);
        add(32'hB0, 1, 0);
        add(32'hB1, 0, 1);
        run(0);
        for (int i = 0; i < 5; i++) add(32'hC0 + i, i == 0 || i == 2, i == 4);
        run(0);
        for (int i = 0; i < 10; i++) add(32'hD0 + i, i == 0, i == 9);
        run(0);
        for (int i = 0; i < 20; i++) add(32'hE0 + i, i == 0, i == 19);
        run(0);
        s_valid = 1; s_start = 1; s_last = 0; s_data = 32'hF0;
        @(negedge clk);
        s_start = 0; s_data = 32'hF1;
        @(negedge clk);
        s_data = 32'hF2; rst = 1;
        @(negedge clk);
        rst = 0; s_valid = 0;
        chk_reset_vals();
        model_drops = 0;
        for (int i = 0; i < 3; i++) add(32'h90 + i, i == 0, i == 2);
        run(0);
        for (int f = 0; f < 20; f++) begin
            int n = $urandom_range(1, 12);
            int o = $urandom_range(0, 2);
            for (int i = 0; i < o; i++) add($urandom, 0, 0);
            for (int i = 0; i < n; i++) add($urandom, i == 0 || $urandom_range(0, 7) == 0, i == n - 1);
            run(1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
